// File: rtl/ff_resp_checker_pkg.sv
// Shared definitions for the flip-flop response checker: FSM state encoding
// and the bit positions of the per-flop mismatch flags.
package ff_resp_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SYNC  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } chk_state_t;

    localparam int CHK_D  = 0;
    localparam int CHK_JK = 1;
    localparam int CHK_T  = 2;

endpackage

// File: rtl/ff_resp_checker_if.sv
// Stimulus and observed-Q bundle shared by the flop benches and the checker.
// The master side drives it; the checker only listens.
interface ff_resp_checker_if;

    logic start;
    logic stop;
    logic d;
    logic j;
    logic k;
    logic dut_rst;
    logic dut_prs;
    logic obs_d;
    logic obs_jk;
    logic obs_t;

    modport master (
        output start, stop, d, j, k, dut_rst, dut_prs, obs_d, obs_jk, obs_t
    );

    modport slave (
        input  start, stop, d, j, k, dut_rst, dut_prs, obs_d, obs_jk, obs_t
    );

endinterface

// File: rtl/ff_resp_checker_ref_model.sv
// Combinational next-state functions of the D, JK and T flops. JK and T
// evolve from the observed Q so a single bad edge cannot cascade.
module ff_resp_checker_ref_model (
    input  logic i_d,
    input  logic i_j,
    input  logic i_k,
    input  logic i_dut_rst,
    input  logic i_dut_prs,
    input  logic i_obs_jk,
    input  logic i_obs_t,
    output logic o_fd,
    output logic o_fjk,
    output logic o_ft
);

    // dut_rst outranks dut_prs on both the D and T flops
    always_comb begin
        o_fd  = i_d;
        o_ft  = i_obs_t ^ i_d;
        o_fjk = i_obs_jk;
        if (i_dut_rst) begin
            o_fd = 1'b0;
            o_ft = 1'b0;
        end else if (i_dut_prs) begin
            o_fd = 1'b1;
            o_ft = 1'b1;
        end
        if (i_j && i_k) begin
            o_fjk = ~i_obs_jk;
        end else if (i_j) begin
            o_fjk = 1'b1;
        end else if (i_k) begin
            o_fjk = 1'b0;
        end
    end

endmodule

// File: rtl/ff_resp_checker.sv
// Cycle-accurate monitor for the D/JK/T flop exercise: runs a reference model
// alongside the DUTs and reports mismatch count, mask and first failing cycle.
module ff_resp_checker
    import ff_resp_checker_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int CYC_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    ff_resp_checker_if.slave s_if,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [2:0]       o_err_mask,
    output logic [CYC_W-1:0] o_first_err_cyc,
    output logic [CYC_W-1:0] o_cyc_cnt
);

    chk_state_t       r_state;
    logic             r_md;
    logic             r_mjk;
    logic             r_mt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_err_cnt;
    logic [2:0]       r_err_mask;
    logic [CYC_W-1:0] r_first_err_cyc;
    logic [CYC_W-1:0] r_cyc_cnt;

    logic             w_fd;
    logic             w_fjk;
    logic             w_ft;
    logic [2:0]       w_mism;
    logic             w_any;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [CYC_W-1:0] w_cyc_cnt_nxt;

    ff_resp_checker_ref_model u_ref (
        .i_d       (s_if.d),
        .i_j       (s_if.j),
        .i_k       (s_if.k),
        .i_dut_rst (s_if.dut_rst),
        .i_dut_prs (s_if.dut_prs),
        .i_obs_jk  (s_if.obs_jk),
        .i_obs_t   (s_if.obs_t),
        .o_fd      (w_fd),
        .o_fjk     (w_fjk),
        .o_ft      (w_ft)
    );

    always_comb begin
        w_mism         = 3'b000;
        w_mism[CHK_D]  = s_if.obs_d  != r_md;
        w_mism[CHK_JK] = s_if.obs_jk != r_mjk;
        w_mism[CHK_T]  = s_if.obs_t  != r_mt;
        w_any          = |w_mism;
    end

    // both counters saturate at all-ones rather than wrapping
    assign w_err_cnt_nxt = (w_any && (r_err_cnt != '1)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
    assign w_cyc_cnt_nxt = (r_cyc_cnt != '1) ? r_cyc_cnt + CYC_W'(1) : r_cyc_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state         <= S_IDLE;
            r_md            <= 1'b0;
            r_mjk           <= 1'b0;
            r_mt            <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_cnt       <= '0;
            r_err_mask      <= 3'b000;
            r_first_err_cyc <= '0;
            r_cyc_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_if.start) begin
                        r_state <= S_SYNC;
                        r_busy  <= 1'b1;
                    end
                end
                S_SYNC: begin
                    r_md            <= w_fd;
                    r_mjk           <= w_fjk;
                    r_mt            <= w_ft;
                    r_err_cnt       <= '0;
                    r_err_mask      <= 3'b000;
                    r_first_err_cyc <= '0;
                    r_cyc_cnt       <= '0;
                    r_state         <= S_CHECK;
                end
                S_CHECK: begin
                    r_md       <= w_fd;
                    r_mjk      <= w_fjk;
                    r_mt       <= w_ft;
                    r_err_cnt  <= w_err_cnt_nxt;
                    r_err_mask <= r_err_mask | w_mism;
                    r_cyc_cnt  <= w_cyc_cnt_nxt;
                    // an empty sticky mask means no error yet in this run
                    if (w_any && (r_err_mask == 3'b000)) begin
                        r_first_err_cyc <= r_cyc_cnt;
                    end
                    if (s_if.stop || (STOP_ON_ERR && w_any)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_cnt_nxt == '0);
                    end
                end
                S_DONE: begin
                    if (s_if.start) begin
                        r_state <= S_SYNC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_err_cnt       = r_err_cnt;
    assign o_err_mask      = r_err_mask;
    assign o_first_err_cyc = r_first_err_cyc;
    assign o_cyc_cnt       = r_cyc_cnt;

endmodule

// File: tb/tb_ff_resp_checker.sv
// Directed bench: three checker instances (default, stop-on-error, 2-bit
// counter) watch the same behavioural D/JK/T flops with injected Q flips.
module tb_ff_resp_checker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ff_resp_checker_if bus ();

    logic        m_busy, m_done, m_pass;
    logic [7:0]  m_err;
    logic [2:0]  m_mask;
    logic [15:0] m_first, m_cyc;
    logic        e_busy, e_done, e_pass;
    logic [7:0]  e_err;
    logic [2:0]  e_mask;
    logic [15:0] e_first, e_cyc;
    logic        s_busy, s_done, s_pass;
    logic [1:0]  s_err;
    logic [2:0]  s_mask;
    logic [15:0] s_first, s_cyc;

    ff_resp_checker u_main (
        .i_clk(clk), .i_rst(rst), .s_if(bus),
        .o_busy(m_busy), .o_done(m_done), .o_pass(m_pass), .o_err_cnt(m_err),
        .o_err_mask(m_mask), .o_first_err_cyc(m_first), .o_cyc_cnt(m_cyc)
    );

    ff_resp_checker #(.STOP_ON_ERR(1'b1)) u_soe (
        .i_clk(clk), .i_rst(rst), .s_if(bus),
        .o_busy(e_busy), .o_done(e_done), .o_pass(e_pass), .o_err_cnt(e_err),
        .o_err_mask(e_mask), .o_first_err_cyc(e_first), .o_cyc_cnt(e_cyc)
    );

    ff_resp_checker #(.CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst(rst), .s_if(bus),
        .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_err_cnt(s_err),
        .o_err_mask(s_mask), .o_first_err_cyc(s_first), .o_cyc_cnt(s_cyc)
    );

    // behavioural flops standing in for the DUTs; flip[] corrupts the held Q
    logic qd  = 1'b0;
    logic qjk = 1'b0;
    logic qt  = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cyc(input logic rs, st, sp, dd, jj, kk, rr, pp, input logic [2:0] flip);
        @(negedge clk);
        qd  = qd  ^ flip[0];
        qjk = qjk ^ flip[1];
        qt  = qt  ^ flip[2];
        rst = rs;
        bus.start = st;   bus.stop = sp;
        bus.d = dd;       bus.j = jj;     bus.k = kk;
        bus.dut_rst = rr; bus.dut_prs = pp;
        bus.obs_d = qd;   bus.obs_jk = qjk; bus.obs_t = qt;
        @(posedge clk);
        qd  = rr ? 1'b0 : pp ? 1'b1 : dd;
        qjk = (jj && kk) ? ~qjk : jj ? 1'b1 : kk ? 1'b0 : qjk;
        qt  = rr ? 1'b0 : pp ? 1'b1 : (qt ^ dd);
        #1;
    endtask

    task automatic idle(input logic sp);
        cyc(1'b1, 1'b0, sp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    endtask

    task automatic begin_run();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(1'b0);
    endtask

    task automatic test_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(1'b0);
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", m_busy); end
        n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", m_done); end
        n_cmp++; if (m_pass !== 1'b0) begin n_bad++; $display("FAIL reset_pass: got %0b want 0", m_pass); end
        n_cmp++; if (m_err !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", m_err); end
        n_cmp++; if (m_mask !== 3'b000) begin n_bad++; $display("FAIL reset_err_mask: got %b want 000", m_mask); end
        n_cmp++; if (m_cyc !== 16'd0) begin n_bad++; $display("FAIL reset_cyc_cnt: got %0d want 0", m_cyc); end
        n_cmp++; if (m_first !== 16'd0) begin n_bad++; $display("FAIL reset_first_err: got %0d want 0", m_first); end
    endtask

    task automatic test_clean();
        logic [3:0] dpat;
        logic [3:0] jpat;
        logic [3:0] kpat;
        dpat = 4'b0110;
        jpat = 4'b1100;
        kpat = 4'b1010;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL clean_busy_sync: got %0b want 1", m_busy); end
        idle(1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, (i == 7), dpat[i%4], jpat[i%4], kpat[i%4], 1'b0, 1'b0, 3'b000);
            if (i == 3) begin
                n_cmp++; if (m_cyc !== 16'd4) begin n_bad++; $display("FAIL clean_cyc_mid: got %0d want 4", m_cyc); end
            end
        end
        n_cmp++; if (m_done !== 1'b1) begin n_bad++; $display("FAIL clean_done: got %0b want 1", m_done); end
        n_cmp++; if (m_pass !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %0b want 1", m_pass); end
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL clean_busy_end: got %0b want 0", m_busy); end
        n_cmp++; if (m_err !== 8'd0) begin n_bad++; $display("FAIL clean_err_cnt: got %0d want 0", m_err); end
        n_cmp++; if (m_cyc !== 16'd8) begin n_bad++; $display("FAIL clean_cyc_cnt: got %0d want 8", m_cyc); end
        idle(1'b1);
        n_cmp++; if (m_done !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %0b want 1", m_done); end
        n_cmp++; if (m_cyc !== 16'd8) begin n_bad++; $display("FAIL done_cyc_hold: got %0d want 8", m_cyc); end
    endtask

    task automatic test_jk_err();
        begin_run();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, (i == 7), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                (i == 3 || i == 5) ? 3'b010 : 3'b000);
        end
        n_cmp++; if (m_err !== 8'd2) begin n_bad++; $display("FAIL jk_err_cnt: got %0d want 2", m_err); end
        n_cmp++; if (m_mask !== 3'b010) begin n_bad++; $display("FAIL jk_err_mask: got %b want 010", m_mask); end
        n_cmp++; if (m_first !== 16'd3) begin n_bad++; $display("FAIL jk_first_err: got %0d want 3", m_first); end
        n_cmp++; if (m_pass !== 1'b0) begin n_bad++; $display("FAIL jk_pass: got %0b want 0", m_pass); end
        n_cmp++; if (m_cyc !== 16'd8) begin n_bad++; $display("FAIL jk_cyc_cnt: got %0d want 8", m_cyc); end
        n_cmp++; if (e_cyc !== 16'd4) begin n_bad++; $display("FAIL jk_soe_cyc: got %0d want 4", e_cyc); end
        n_cmp++; if (e_err !== 8'd1) begin n_bad++; $display("FAIL jk_soe_err: got %0d want 1", e_err); end
        n_cmp++; if (s_err !== 2'd2) begin n_bad++; $display("FAIL jk_sat_err: got %0d want 2", s_err); end
    endtask

    task automatic test_rst_prs();
        begin_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        n_cmp++; if (m_err !== 8'd0) begin n_bad++; $display("FAIL rp_no_err: got %0d want 0", m_err); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_err !== 8'd1) begin n_bad++; $display("FAIL rp_err_cnt: got %0d want 1", m_err); end
        n_cmp++; if (m_mask !== 3'b001) begin n_bad++; $display("FAIL rp_err_mask: got %b want 001", m_mask); end
        n_cmp++; if (m_first !== 16'd2) begin n_bad++; $display("FAIL rp_first_err: got %0d want 2", m_first); end
        n_cmp++; if (m_cyc !== 16'd4) begin n_bad++; $display("FAIL rp_cyc_cnt: got %0d want 4", m_cyc); end
    endtask

    task automatic test_stop_on_err();
        begin_run();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b0, (i == 6), (i % 2 == 1), 1'b0, 1'b0, 1'b0, 1'b0,
                (i == 4) ? 3'b100 : 3'b000);
            if (i == 4) begin
                n_cmp++; if (e_done !== 1'b1) begin n_bad++; $display("FAIL soe_done: got %0b want 1", e_done); end
                n_cmp++; if (e_busy !== 1'b0) begin n_bad++; $display("FAIL soe_busy: got %0b want 0", e_busy); end
            end
        end
        n_cmp++; if (e_err !== 8'd1) begin n_bad++; $display("FAIL soe_err_cnt: got %0d want 1", e_err); end
        n_cmp++; if (e_first !== 16'd4) begin n_bad++; $display("FAIL soe_first_err: got %0d want 4", e_first); end
        n_cmp++; if (e_cyc !== 16'd5) begin n_bad++; $display("FAIL soe_cyc_cnt: got %0d want 5", e_cyc); end
        n_cmp++; if (e_mask !== 3'b100) begin n_bad++; $display("FAIL soe_err_mask: got %b want 100", e_mask); end
        n_cmp++; if (m_cyc !== 16'd7) begin n_bad++; $display("FAIL soe_main_cyc: got %0d want 7", m_cyc); end
        n_cmp++; if (m_err !== 8'd1) begin n_bad++; $display("FAIL soe_main_err: got %0d want 1", m_err); end
    endtask

    task automatic test_saturate();
        begin_run();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, (i == 7), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                (i < 6) ? 3'b001 : 3'b000);
        end
        n_cmp++; if (s_err !== 2'd3) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want 3", s_err); end
        n_cmp++; if (m_err !== 8'd6) begin n_bad++; $display("FAIL sat_main_err: got %0d want 6", m_err); end
        n_cmp++; if (s_mask !== 3'b001) begin n_bad++; $display("FAIL sat_err_mask: got %b want 001", s_mask); end
        n_cmp++; if (s_first !== 16'd0) begin n_bad++; $display("FAIL sat_first_err: got %0d want 0", s_first); end
        n_cmp++; if (s_pass !== 1'b0) begin n_bad++; $display("FAIL sat_pass: got %0b want 0", s_pass); end
        n_cmp++; if (s_done !== 1'b1) begin n_bad++; $display("FAIL sat_done: got %0b want 1", s_done); end
    endtask

    task automatic test_rst_mid();
        begin_run();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (i == 1) ? 3'b001 : 3'b000);
        end
        n_cmp++; if (m_err !== 8'd1) begin n_bad++; $display("FAIL mid_err_pre: got %0d want 1", m_err); end
        n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %0b want 1", m_busy); end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b want 0", m_busy); end
        n_cmp++; if (m_err !== 8'd0) begin n_bad++; $display("FAIL mid_err_cnt: got %0d want 0", m_err); end
        n_cmp++; if (m_mask !== 3'b000) begin n_bad++; $display("FAIL mid_err_mask: got %b want 000", m_mask); end
        n_cmp++; if (m_first !== 16'd0) begin n_bad++; $display("FAIL mid_first_err: got %0d want 0", m_first); end
        n_cmp++; if (m_cyc !== 16'd0) begin n_bad++; $display("FAIL mid_cyc_cnt: got %0d want 0", m_cyc); end
        n_cmp++; if (s_busy !== 1'b0) begin n_bad++; $display("FAIL mid_sat_busy: got %0b want 0", s_busy); end
        idle(1'b0);
        n_cmp++; if (m_busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle_busy: got %0b want 0", m_busy); end
    endtask

    task automatic test_start_stop();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL ss_idle_busy: got %0b want 1", m_busy); end
        idle(1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_done !== 1'b1) begin n_bad++; $display("FAIL ss_check_done: got %0b want 1", m_done); end
        n_cmp++; if (m_cyc !== 16'd1) begin n_bad++; $display("FAIL ss_check_cyc: got %0d want 1", m_cyc); end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        n_cmp++; if (m_busy !== 1'b1) begin n_bad++; $display("FAIL ss_done_busy: got %0b want 1", m_busy); end
        n_cmp++; if (m_done !== 1'b0) begin n_bad++; $display("FAIL ss_done_clr: got %0b want 0", m_done); end
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        idle(1'b1);
        n_cmp++; if (m_done !== 1'b1) begin n_bad++; $display("FAIL ss_sync_start: got %0b want 1", m_done); end
        n_cmp++; if (m_cyc !== 16'd1) begin n_bad++; $display("FAIL ss_final_cyc: got %0d want 1", m_cyc); end
        n_cmp++; if (m_pass !== 1'b1) begin n_bad++; $display("FAIL ss_pass: got %0b want 1", m_pass); end
    endtask

    initial begin
        bus.start = 1'b0;   bus.stop = 1'b0;
        bus.d = 1'b0;       bus.j = 1'b0;      bus.k = 1'b0;
        bus.dut_rst = 1'b0; bus.dut_prs = 1'b0;
        bus.obs_d = 1'b0;   bus.obs_jk = 1'b0; bus.obs_t = 1'b0;
        test_reset();
        test_clean();
        test_jk_err();
        test_rst_prs();
        test_stop_on_err();
        test_saturate();
        test_rst_mid();
        test_start_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
